cmn_seq_multiplier: RTL and testbench
=====================================

# cmn_seq_multiplier

Iterative shift-and-add integer multiplier producing a full double-width product, with val/rdy handshakes on both sides. It retires a configurable number of multiplier bits per cycle and supports signed or unsigned operation selected per transaction. It sits beside the combinational arithmetic primitives as the area-efficient choice where a single-cycle `*` is too large or too slow, for example in DSP accumulators and address-scaling paths.

## Interface
- `p_nbits`, default 32: operand width N; must be ≥ 2.
- `p_bits_per_cycle`, default 1: multiplier bits retired per CALC cycle, K; must divide `p_nbits`.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: reset, synchronous and active-low (asserted when 0, sampled on the rising edge of `clk`).
- `recv_val`, input, 1: operand request valid.
- `recv_rdy`, output, 1: block can accept operands.
- `recv_a`, input, N: multiplicand.
- `recv_b`, input, N: multiplier.
- `recv_signed`, input, 1: 1 means two's-complement operands; 0 means unsigned.
- `send_val`, output, 1: product valid.
- `send_rdy`, input, 1: consumer accepts the product.
- `send_msg`, output, 2N: product.

## Operation
- FSM states are IDLE, CALC and DONE; the reset state is IDLE.
- IDLE:
  - `recv_rdy`=1.
  - On `recv_val`&&`recv_rdy`, capture the operands.
  - In signed mode, replace each operand with its magnitude, held in N bits unsigned, and record `neg` = a[N-1]^b[N-1]. In unsigned mode, `neg`=0.
  - Clear the accumulator to 0, load the step counter with N/K, and go to CALC.
- CALC, each cycle:
  - acc += a_sh × b[K-1:0], where a_sh is held at 2N bits.
  - a_sh <<= K; b >>= K; count -= 1.
  - Go to DONE when the count reaches 0.
- DONE:
  - `send_val`=1.
  - `send_msg` = `neg` ? −acc : acc, both 2N bits.
  - On `send_rdy`, go to IDLE.
- `recv_rdy`=0 in CALC and DONE. There is no overlap between consecutive transactions.
- Width rules:
  - All arithmetic is modulo 2^(2N); no overflow is possible.
  - The −2^(N−1) magnitude is exactly 2^(N−1) and fits in N unsigned bits.
  - (−2^(N−1))² = 2^(2N−2) is representable as a positive 2N-bit value.
- `send_msg` is held stable while `send_val`=1 and `send_rdy`=0.
- Inputs other than `send_rdy` are ignored outside IDLE.
- Reset asserted in any state (including mid-CALC or DONE with a product pending):
  - Next cycle is IDLE, with `send_val`=0 and `recv_rdy`=1.
  - The in-flight product is discarded.
- Output reset values are `recv_rdy`=1, `send_val`=0 and `send_msg`=0 (acc cleared, `neg` cleared).

## Timing
- The request handshake completes at rising edge t.
- Without early exit, CALC occupies N/K cycles and `send_val` rises in cycle t+N/K+1. Example: N=32, K=1 gives 33 cycles from accept to valid.
- After the send handshake at edge u, `recv_rdy`=1 in cycle u+1.
- Minimum initiation interval is N/K+2 cycles.
- `recv_rdy` and `send_val` are pure state decodes with no combinational path from inputs.

## Configuration
- Macro: `CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN`.
- With the macro defined, CALC also moves to DONE at the end of any cycle in which the post-shift multiplier register is zero. Latency is then ceil(index of the highest set bit of |b| + 1, in K-bit chunks) CALC cycles, with a minimum of 1 (b=0 takes 1 CALC cycle).
- Without the macro, latency is always exactly N/K CALC cycles.
- Results are identical in both builds.

## Structure
- Package `cmn_seq_multiplier_pkg` holds:
  - the state enum `cmn_seq_mul_state_t` (IDLE, CALC, DONE);
  - a function returning the counter width, $clog2(N/K+1).
- A natural split into two sub-modules:
  - `cmn_seq_multiplier_dpath` (registers a_sh, b, acc, count, neg; the K-bit partial-product adder tree; the final negation).
  - A control FSM in the top module driving load, step and hold signals and receiving count==0 and b==0 status.

## Test plan
All scenarios use N=8, K=1 unless stated otherwise.
- Unsigned 13×11: `send_msg`=16'h008F, with `send_val` in cycle t+9 (no early exit).
- Signed −3×5: `send_msg`=16'hFFF1. Signed −128×−128: `send_msg`=16'h4000.
- Unsigned 255×255: `send_msg`=16'hFE01. The same operands with K=4 give the same value with `send_val` in cycle t+3.
- Hold `send_rdy`=0 for 5 cycles in DONE: `send_msg` stays stable, `recv_rdy`=0, and a `recv_val` pulse is ignored. Raise `send_rdy`: `recv_rdy`=1 in the next cycle.
- Early-exit build, unsigned 200×0: `send_val` in cycle t+2 with 16'h0000. Unsigned 7×3: 2 CALC cycles, result 16'h0015.
- Assert `reset` (drive 0) for 1 cycle during the 4th CALC cycle: next cycle is IDLE with `send_val`=0 and `recv_rdy`=1. A new 2×3 request then yields 16'h0006.

Source files
------------

// File: rtl/cmn_seq_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Holds the control FSM state enum and the step-counter width function.
package cmn_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } cmn_seq_mul_state_t;

    // Width needed to hold the step count n/k (inclusive).
    function automatic int cmn_seq_mul_cnt_w(input int n, input int k);
        return $clog2(n / k + 1);
    endfunction

endpackage

// File: rtl/cmn_seq_multiplier_if.sv
// Operand request and product response handshakes for the multiplier.
// master = requester/consumer side, slave = the multiplier itself.
interface cmn_seq_multiplier_if #(
    parameter int p_nbits = 32
);
    logic                   recv_val;
    logic                   recv_rdy;
    logic [p_nbits-1:0]     recv_a;
    logic [p_nbits-1:0]     recv_b;
    logic                   recv_signed;
    logic                   send_val;
    logic                   send_rdy;
    logic [2*p_nbits-1:0]   send_msg;

    modport master (
        output recv_val, recv_a, recv_b, recv_signed, send_rdy,
        input  recv_rdy, send_val, send_msg
    );

    modport slave (
        input  recv_val, recv_a, recv_b, recv_signed, send_rdy,
        output recv_rdy, send_val, send_msg
    );
endinterface

// File: rtl/cmn_seq_multiplier_dpath.sv
// Datapath: operand magnitudes, shift registers, K-bit partial-product adder.
// Optional CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN ends CALC once the multiplier empties.
module cmn_seq_multiplier_dpath
    import cmn_seq_multiplier_pkg::*;
#(
    parameter int p_nbits          = 32,
    parameter int p_bits_per_cycle = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [p_nbits-1:0]   a,
    input  logic [p_nbits-1:0]   b,
    input  logic                 sgn,
    output logic [2*p_nbits-1:0] msg,
    output logic                 last
);
    localparam int N  = p_nbits;
    localparam int K  = p_bits_per_cycle;
    localparam int CW = cmn_seq_mul_cnt_w(N, K);
    localparam logic [CW-1:0] STEPS = CW'(N / K);

    logic [2*N-1:0] a_sh_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] pp;
    logic [N-1:0]   b_nxt;

    // Signed operands become magnitudes; -2^(N-1) maps to 2^(N-1).
    assign a_mag = (sgn && a[N-1]) ? (~a + 1'b1) : a;
    assign b_mag = (sgn && b[N-1]) ? (~b + 1'b1) : b;
    assign b_nxt = b_q >> K;

    // Sum of the shifted multiplicand for each set bit of the low K-bit chunk.
    always_comb begin
        pp = '0;
        for (int i = 0; i < K; i++) begin
            if (b_q[i]) pp = pp + (a_sh_q << i);
        end
    end

    // Operand load on accept, one K-bit step per CALC cycle, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sh_q <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
        end else if (load) begin
            a_sh_q <= {{N{1'b0}}, a_mag};
            b_q    <= b_mag;
            acc_q  <= '0;
            cnt_q  <= STEPS;
            neg_q  <= sgn & (a[N-1] ^ b[N-1]);
        end else if (step) begin
            a_sh_q <= a_sh_q << K;
            b_q    <= b_nxt;
            acc_q  <= acc_q + pp;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

`ifdef CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN
    assign last = (cnt_q == CW'(1)) || (b_nxt == '0);
`else
    assign last = (cnt_q == CW'(1));
`endif

    assign msg = neg_q ? (~acc_q + 1'b1) : acc_q;

endmodule

// File: rtl/cmn_seq_multiplier.sv
// Iterative signed/unsigned multiplier, full 2N-bit product, val/rdy both sides.
// Build option CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN shortens CALC for small multipliers.
module cmn_seq_multiplier
    import cmn_seq_multiplier_pkg::*;
#(
    parameter int p_nbits          = 32,
    parameter int p_bits_per_cycle = 1
) (
    input  logic            clk,
    input  logic            reset,
    cmn_seq_multiplier_if.slave io
);
    cmn_seq_mul_state_t state_q;
    cmn_seq_mul_state_t state_d;

    logic load;
    logic step;
    logic last;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.recv_val) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (io.send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.recv_rdy = (state_q == IDLE);
    assign io.send_val = (state_q == DONE);

    cmn_seq_multiplier_dpath #(
        .p_nbits          (p_nbits),
        .p_bits_per_cycle (p_bits_per_cycle)
    ) u_dpath (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a     (io.recv_a),
        .b     (io.recv_b),
        .sgn   (io.recv_signed),
        .msg   (io.send_msg),
        .last  (last)
    );

endmodule

// File: tb/tb_cmn_seq_multiplier.sv
// Directed bench for cmn_seq_multiplier, N=8 with K=1 and K=4 instances.
// Latency expectations follow CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN when defined.
module tb_cmn_seq_multiplier;
    import cmn_seq_multiplier_pkg::*;

`ifdef CMN_SEQ_MULTIPLIER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cmn_seq_multiplier_if #(.p_nbits(8)) if1 ();
    cmn_seq_multiplier_if #(.p_nbits(8)) if4 ();

    cmn_seq_multiplier #(.p_nbits(8), .p_bits_per_cycle(1)) u_k1 (
        .clk   (clk),
        .reset (reset),
        .io    (if1.slave)
    );

    cmn_seq_multiplier #(.p_nbits(8), .p_bits_per_cycle(4)) u_k4 (
        .clk   (clk),
        .reset (reset),
        .io    (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit sel, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic s);
        if (sel) begin
            if4.recv_val = v; if4.recv_a = a;
            if4.recv_b = b; if4.recv_signed = s;
        end else begin
            if1.recv_val = v; if1.recv_a = a;
            if1.recv_b = b; if1.recv_signed = s;
        end
    endtask

    task automatic set_srdy(input bit sel, input logic v);
        if (sel) if4.send_rdy = v;
        else     if1.send_rdy = v;
    endtask

    function automatic logic get_rrdy(input bit sel);
        return sel ? if4.recv_rdy : if1.recv_rdy;
    endfunction

    function automatic logic get_sval(input bit sel);
        return sel ? if4.send_val : if1.send_val;
    endfunction

    function automatic logic [15:0] get_msg(input bit sel);
        return sel ? if4.send_msg : if1.send_msg;
    endfunction

    // One transaction: accept, measure latency, optionally stall, release.
    task automatic do_mul(input string tag, input bit sel,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic sgn, input logic [15:0] exp,
                          input int ee_calc, input int hold);
        int lat;
        int exp_lat;
        exp_lat = EE ? ee_calc + 1 : (sel ? 3 : 9);
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(get_rrdy(sel)), 32'd1);
        set_req(sel, 1'b1, a, b, sgn);
        @(posedge clk);
        @(negedge clk);
        set_req(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        lat = 1;
        while (!get_sval(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".msg"}, 32'(get_msg(sel)), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            if (h == 0) set_req(sel, 1'b1, 8'h01, 8'h01, 1'b0);
            else        set_req(sel, 1'b0, 8'h00, 8'h00, 1'b0);
            @(negedge clk);
            chk({tag, ".hval"}, 32'(get_sval(sel)), 32'd1);
            chk({tag, ".hmsg"}, 32'(get_msg(sel)), 32'(exp));
            chk({tag, ".hrdy"}, 32'(get_rrdy(sel)), 32'd0);
        end
        set_req(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        set_srdy(sel, 1'b1);
        @(negedge clk);
        set_srdy(sel, 1'b0);
        chk({tag, ".nrdy"}, 32'(get_rrdy(sel)), 32'd1);
        chk({tag, ".nval"}, 32'(get_sval(sel)), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_srdy(1'b0, 1'b0);
        set_srdy(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst.rdy1", 32'(if1.recv_rdy), 32'd1);
        chk("rst.val1", 32'(if1.send_val), 32'd0);
        chk("rst.msg1", 32'(if1.send_msg), 32'd0);
        chk("rst.rdy4", 32'(if4.recv_rdy), 32'd1);
        chk("rst.val4", 32'(if4.send_val), 32'd0);
        chk("rst.msg4", 32'(if4.send_msg), 32'd0);
        reset = 1'b1;

        do_mul("u13x11",   1'b0, 8'd13,  8'd11,  1'b0, 16'h008F, 4, 0);
        do_mul("s-3x5",    1'b0, 8'hFD,  8'd5,   1'b1, 16'hFFF1, 3, 0);
        do_mul("s-128sq",  1'b0, 8'h80,  8'h80,  1'b1, 16'h4000, 8, 0);
        do_mul("u255sq",   1'b0, 8'hFF,  8'hFF,  1'b0, 16'hFE01, 8, 0);
        do_mul("u128sq",   1'b0, 8'h80,  8'h80,  1'b0, 16'h4000, 8, 0);
        do_mul("s127x-128",1'b0, 8'h7F,  8'h80,  1'b1, 16'hC080, 8, 0);
        do_mul("s5x-1",    1'b0, 8'd5,   8'hFF,  1'b1, 16'hFFFB, 1, 0);
        do_mul("u3x129",   1'b0, 8'd3,   8'h81,  1'b0, 16'h0183, 8, 0);
        do_mul("u200x0",   1'b0, 8'd200, 8'd0,   1'b0, 16'h0000, 1, 0);
        do_mul("u7x3",     1'b0, 8'd7,   8'd3,   1'b0, 16'h0015, 2, 0);
        do_mul("hold",     1'b0, 8'd9,   8'd6,   1'b0, 16'h0036, 3, 5);
        do_mul("k4u255sq", 1'b1, 8'hFF,  8'hFF,  1'b0, 16'hFE01, 2, 0);
        do_mul("k4s-3x5",  1'b1, 8'hFD,  8'd5,   1'b1, 16'hFFF1, 1, 0);
        do_mul("k4s-128sq",1'b1, 8'h80,  8'h80,  1'b1, 16'h4000, 2, 0);

        @(negedge clk);
        set_req(1'b0, 1'b1, 8'd100, 8'd100, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid.calc", 32'(if1.recv_rdy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid.val", 32'(if1.send_val), 32'd0);
        chk("mid.rdy", 32'(if1.recv_rdy), 32'd1);
        chk("mid.msg", 32'(if1.send_msg), 32'd0);
        do_mul("u2x3", 1'b0, 8'd2, 8'd3, 1'b0, 16'h0006, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
